cb: RTL and testbench

Circular buffer (FIFO) with a single write port and a single read port. Enqueue is always accepted; the block has no backpressure on the write side. Dequeue uses a valid/ready handshake. It is used as a lightweight decoupling queue between a producer that cannot stall and a consumer that can.

---
 rtl/cb.sv | 105 ++++++++++
 tb/tb_cb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cb.sv
// ---------------------------------------------------------------------------
// cb : circular buffer (FIFO) with one write port and one read port.
//
// The producer can never be stalled: every enqueue is accepted. Enqueueing
// into a full buffer with no simultaneous dequeue drops everything queued so
// far and keeps only the new entry. The read side uses a valid/ready
// handshake. Outputs come only from registered state (no bypass), so an
// entry enqueued on edge N is first visible after edge N.
//
// Parameters
//   DATA_WIDTH       width of each stored entry
//   NUM_ENTRIES      depth, power of 2 and >= 2
//   LOG_NUM_ENTRIES  pointer width
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   enq_valid  in   enqueue request (always accepted)
//   enq_data   in   data to enqueue
//   deq_valid  out  buffer is non-empty
//   deq_data   out  entry at the head pointer (stale data when empty)
//   deq_ready  in   consumer takes the head entry this cycle
// ---------------------------------------------------------------------------
module cb #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_ENTRIES     = 4,
  parameter int LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_data,
  input  logic                  deq_ready
);

  logic [DATA_WIDTH-1:0]      mem [NUM_ENTRIES];
  logic [LOG_NUM_ENTRIES-1:0] head, tail;
  logic                       full;

  logic [LOG_NUM_ENTRIES-1:0] head_nxt, tail_nxt;
  logic [LOG_NUM_ENTRIES-1:0] head_inc, tail_inc;
  logic                       full_nxt;
  logic                       deq_fire;

  // Depth is a power of 2, so plain binary increment wraps modulo NUM_ENTRIES.
  assign head_inc = head + LOG_NUM_ENTRIES'(1);
  assign tail_inc = tail + LOG_NUM_ENTRIES'(1);

  // Outputs are pure functions of registered state.
  assign deq_valid = full | (head != tail);
  assign deq_data  = mem[head];
  assign deq_fire  = deq_valid & deq_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    full_nxt = full;
    if (enq_valid && deq_fire) begin
      // Simultaneous enqueue and dequeue: occupancy unchanged, full kept.
      head_nxt = head_inc;
      tail_nxt = tail_inc;
    end else if (enq_valid) begin
      tail_nxt = tail_inc;
      if (full) begin
        // Overflow: tail == head, so the write lands on the head slot and the
        // buffer is left holding exactly the new entry.
        full_nxt = 1'b0;
      end else begin
        full_nxt = (tail_inc == head);
      end
    end else if (deq_fire) begin
      head_nxt = head_inc;
      full_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
      full <= 1'b0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      full <= full_nxt;
    end
  end

  // NOTE: the storage array is reset as well, because deq_data exposes the
  // head slot even when empty and must read 0 after reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
    end else if (enq_valid) begin
      mem[tail] <= enq_data;
    end
  end

endmodule

// File: tb/tb_cb.sv
// ---------------------------------------------------------------------------
// tb_cb : self-checking bench for cb (DATA_WIDTH=32, NUM_ENTRIES=4).
// A behavioural model tracks the slot contents, head index and occupancy
// count; it is updated after each rising edge from the inputs applied that
// cycle, and the DUT outputs are compared #1 after the edge.
// ---------------------------------------------------------------------------
module tb_cb;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          CLK;
  logic          nRST;
  logic          enq_valid;
  logic [DW-1:0] enq_data;
  logic          deq_valid;
  logic [DW-1:0] deq_data;
  logic          deq_ready;

  int total = 0;
  int bad   = 0;

  // Reference model: slot array, head index, occupancy count.
  logic [DW-1:0] m_mem [N];
  int            m_head;
  int            m_cnt;

  cb #(.DATA_WIDTH(DW), .NUM_ENTRIES(N)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_head = 0;
    m_cnt  = 0;
  endfunction

  function automatic void model_cycle(input logic e, input logic [DW-1:0] d, input logic r);
    bit fire;
    fire = (m_cnt > 0) && r;
    if (e) begin
      m_mem[(m_head + m_cnt) % N] = d;
      if (fire)            m_head = (m_head + 1) % N;
      else if (m_cnt == N) m_cnt  = 1;  // overflow keeps only the new entry
      else                 m_cnt  = m_cnt + 1;
    end else if (fire) begin
      m_head = (m_head + 1) % N;
      m_cnt  = m_cnt - 1;
    end
  endfunction

  // Apply inputs, take one rising edge, advance the model, settle.
  task automatic step(input logic e, input logic [DW-1:0] d, input logic r);
    enq_valid = e;
    enq_data  = d;
    deq_ready = r;
    @(posedge CLK);
    model_cycle(e, d, r);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    model_reset();
    #2;
    total++;
    if (deq_valid !== 1'b0 || deq_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_during: valid=%b data=%h required valid=0 data=0", deq_valid, deq_data);
    end
    @(posedge CLK); @(posedge CLK);
    #3 nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, i[0]);
      total++;
      if (deq_valid !== 1'b0 || deq_data !== 32'h0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: valid=%b data=%h required valid=0 data=0", i, deq_valid, deq_data);
      end
    end
  endtask

  // Streaming with wrap, fill, overflow, drain and refill, with the
  // expected outputs written out literally.
  task automatic test_directed();
    logic          e [18] = '{1,1,1,1,1, 1,1,1, 1, 1,1,1,1, 0, 1, 0,0,0};
    logic [DW-1:0] d [18] = '{32'hf0f0f0f0, 32'he1e1e1e1, 32'hd2d2d2d2, 32'hc3c3c3c3, 32'hb4b4b4b4,
                              32'ha5a5a5a5, 32'h96969696, 32'h87878787,
                              32'h78787878,
                              32'h69696969, 32'h5a5a5a5a, 32'h4b4b4b4b, 32'h3c3c3c3c,
                              32'h0, 32'h2d2d2d2d, 32'h0, 32'h0, 32'h0};
    logic          r [18] = '{1,1,1,1,1, 0,0,0, 0, 1,1,1,1, 1, 1, 1,1,0};
    logic          xv[18] = '{1,1,1,1,1, 1,1,1, 1, 1,1,1,1, 0, 1, 0,0,0};
    logic [DW-1:0] xd[18] = '{32'hf0f0f0f0, 32'he1e1e1e1, 32'hd2d2d2d2, 32'hc3c3c3c3, 32'hb4b4b4b4,
                              32'hb4b4b4b4, 32'hb4b4b4b4, 32'hb4b4b4b4,
                              32'h78787878,
                              32'h69696969, 32'h5a5a5a5a, 32'h4b4b4b4b, 32'h3c3c3c3c,
                              32'h69696969, 32'h2d2d2d2d, 32'h5a5a5a5a, 32'h5a5a5a5a, 32'h5a5a5a5a};
    for (int i = 0; i < 18; i++) begin
      step(e[i], d[i], r[i]);
      total++;
      if (deq_valid !== xv[i] || deq_data !== xd[i]) begin
        bad++;
        $display("FAIL directed[%0d]: valid=%b data=%h required valid=%b data=%h",
                 i, deq_valid, deq_data, xv[i], xd[i]);
      end
    end
  endtask

  task automatic test_random();
    logic          e, r;
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      d = $urandom;
      step(e, d, r);
      total++;
      if (deq_valid !== (m_cnt > 0) || deq_data !== m_mem[m_head]) begin
        bad++;
        $display("FAIL random[%0d]: valid=%b data=%h required valid=%b data=%h",
                 i, deq_valid, deq_data, (m_cnt > 0), m_mem[m_head]);
      end
      // Changing inputs between edges must not disturb the outputs.
      if (i % 50 == 0) begin
        enq_data  = ~enq_data;
        deq_ready = ~deq_ready;
        enq_valid = ~enq_valid;
        #1;
        total++;
        if (deq_valid !== (m_cnt > 0) || deq_data !== m_mem[m_head]) begin
          bad++;
          $display("FAIL no_comb_path[%0d]: valid=%b data=%h required valid=%b data=%h",
                   i, deq_valid, deq_data, (m_cnt > 0), m_mem[m_head]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h11112222, 1'b0);
    step(1'b1, 32'h33334444, 1'b0);
    #2 nRST = 1'b0;
    model_reset();
    #1;
    total++;
    if (deq_valid !== 1'b0 || deq_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b data=%h required valid=0 data=0", deq_valid, deq_data);
    end
    @(negedge CLK) nRST = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    total++;
    if (deq_valid !== 1'b0 || deq_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_after: valid=%b data=%h required valid=0 data=0", deq_valid, deq_data);
    end
    step(1'b1, 32'hcafef00d, 1'b0);
    total++;
    if (deq_valid !== 1'b1 || deq_data !== 32'hcafef00d) begin
      bad++;
      $display("FAIL reset_mid_refill: valid=%b data=%h required valid=1 data=cafef00d", deq_valid, deq_data);
    end
  endtask

  initial begin
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
